// File: rtl/prod_accum_pkg.sv
// Shared definitions for the product accumulation stage: FSM state encoding
// and default widths matching the 64x64 array multiplier.
package prod_accum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int PROD_W = 128;
    localparam int CNT_W  = 8;
    localparam int ACC_W  = 136;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

endpackage

// File: rtl/prod_accum_seq_acc_add_sat.sv
// acc_add_sat: combinational ACC_W adder with a zero-extended PROD_W operand.
// Optional build macro ACC_SAT_EN: on carry out the sum clamps to all-ones
// instead of wrapping. The carry is reported in either build.
module acc_add_sat #(
    parameter int PROD_W = 128,
    parameter int ACC_W  = 136
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              carry_o
);

    logic [ACC_W:0] full_sum;

    // One extra bit on the left captures the carry out of ACC_W.
    assign full_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
    assign carry_o  = full_sum[ACC_W];

`ifdef ACC_SAT_EN
    // Clamp: once saturated, acc stays all-ones since any nonzero add carries again.
    assign sum_o = carry_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];
`else
    // Modular wrap.
    assign sum_o = full_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/prod_accum_seq.sv
// prod_accum_seq: sums groups of unsigned multiplier products and returns one
// result per group under valid/ready. A group closes on in_last or after
// MAX_TERMS beats. Optional build macro ACC_SAT_EN selects saturating instead
// of wrapping accumulation.
module prod_accum_seq
    import prod_accum_pkg::*;
#(
    parameter int PROD_W    = prod_accum_pkg::PROD_W,
    parameter int CNT_W     = prod_accum_pkg::CNT_W,
    parameter int ACC_W     = prod_accum_pkg::ACC_W,
    parameter int MAX_TERMS = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_forced,
    output logic              out_ovf
);

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   count_q;
    logic               ovf_q;
    logic               forced_q;
    logic               out_valid_q;

    logic               accept;
    logic [ACC_W-1:0]   add_base;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic [CNT_W-1:0]   count_d;
    logic               ovf_d;
    logic               group_close;

    // Ready depends only on state and clr so it never waits on in_valid.
    assign in_ready = (state_q != DRAIN) && !clr;
    assign accept   = in_valid && in_ready;

    // The first beat of a group starts from zero; later beats add to acc.
    assign add_base = (state_q == IDLE) ? '0 : acc_q;
    assign count_d  = (state_q == IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
    assign ovf_d    = ((state_q == ACCUM) && ovf_q) || add_carry;

    assign group_close = in_last || (count_d == CNT_W'(MAX_TERMS));

    acc_add_sat #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc_i   (add_base),
        .prod_i  (in_prod),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // Group FSM: accumulate beats, hold the result in DRAIN until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            forced_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            forced_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_q   <= add_sum;
                        count_q <= count_d;
                        ovf_q   <= ovf_d;
                        if (group_close) begin
                            state_q     <= DRAIN;
                            out_valid_q <= 1'b1;
                            forced_q    <= !in_last;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        count_q     <= '0;
                        ovf_q       <= 1'b0;
                        forced_q    <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Result fields are the held accumulator registers themselves.
    assign out_valid  = out_valid_q;
    assign out_sum    = acc_q;
    assign out_count  = count_q;
    assign out_forced = forced_q;
    assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_prod_accum_seq.sv
// Scoreboard bench for prod_accum_seq (ACC_W=129, MAX_TERMS=4). The driver
// keeps a per-group term list and computes each group's result from the exact
// integer total; a monitor pops and compares whenever a result is handed off.
module tb_prod_accum_seq;

    localparam int PW = 128;
    localparam int CW = 8;
    localparam int AW = 129;
    localparam int MT = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_count;
    logic          out_forced;
    logic          out_ovf;

    typedef struct {
        logic [AW-1:0] sum;
        int            count;
        bit            forced;
        bit            ovf;
    } res_t;

    res_t          exp_q[$];
    logic [PW-1:0] terms[$];
    bit            draining;
    int            n_chk;
    int            n_pass;

    always #5 clk = ~clk;

    prod_accum_seq #(
        .PROD_W    (PW),
        .CNT_W     (CW),
        .ACC_W     (AW),
        .MAX_TERMS (MT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_prod    (in_prod),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_count  (out_count),
        .out_forced (out_forced),
        .out_ovf    (out_ovf)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    // Reference: exact integer total of the group, then wrap or clamp.
    function automatic res_t group_result(input bit last);
        res_t         r;
        logic [143:0] total;
        total = '0;
        foreach (terms[i]) total = total + 144'(terms[i]);
        r.count  = terms.size();
        r.forced = !last;
        r.ovf    = (total >= (144'(1) << AW));
`ifdef ACC_SAT_EN
        r.sum    = r.ovf ? {AW{1'b1}} : total[AW-1:0];
`else
        r.sum    = total[AW-1:0];
`endif
        return r;
    endfunction

    // One clock of stimulus; called just after a rising edge.
    task automatic step(input bit v, input logic [PW-1:0] p, input bit l,
                        input bit ordy, input bit c);
        bit exp_rdy;
        bit acc;
        res_t r;
        in_valid  = v;
        in_prod   = p;
        in_last   = l;
        out_ready = ordy;
        clr       = c;
        @(negedge clk);
        exp_rdy = !draining && !c;
        chk("in_ready", 256'(in_ready), 256'(exp_rdy));
        chk("out_valid", 256'(out_valid), 256'(draining));
        acc = v && exp_rdy;
        @(posedge clk);
        if (c) begin
            if (draining) void'(exp_q.pop_back());
            draining = 0;
            terms.delete();
        end else if (draining) begin
            if (ordy) draining = 0;
        end else if (acc) begin
            terms.push_back(p);
            if (l || terms.size() == MT) begin
                r = group_result(l);
                exp_q.push_back(r);
                $display("group closed: count=%0d sum=%0h forced=%0b ovf=%0b",
                         r.count, r.sum, r.forced, r.ovf);
                terms.delete();
                draining = 1;
            end
        end
        #1;
    endtask

    // Monitor: compare on handoff, and require stable outputs while stalled.
    logic [AW-1:0] h_sum;
    logic [CW-1:0] h_count;
    logic          h_forced;
    logic          h_ovf;
    bit            hold;
    res_t          mon_r;

    always @(negedge clk) begin
        if (!rst_n || clr) begin
            hold = 0;
        end else if (out_valid) begin
            if (hold) begin
                chk("stall_sum", 256'(out_sum), 256'(h_sum));
                chk("stall_count", 256'(out_count), 256'(h_count));
                chk("stall_forced", 256'(out_forced), 256'(h_forced));
                chk("stall_ovf", 256'(out_ovf), 256'(h_ovf));
            end
            if (out_ready) begin
                hold = 0;
                chk("result_expected", 256'(exp_q.size() != 0), 256'(1));
                if (exp_q.size() != 0) begin
                    mon_r = exp_q.pop_front();
                    chk("out_sum", 256'(out_sum), 256'(mon_r.sum));
                    chk("out_count", 256'(out_count), 256'(mon_r.count));
                    chk("out_forced", 256'(out_forced), 256'(mon_r.forced));
                    chk("out_ovf", 256'(out_ovf), 256'(mon_r.ovf));
                end
            end else begin
                hold     = 1;
                h_sum    = out_sum;
                h_count  = out_count;
                h_forced = out_forced;
                h_ovf    = out_ovf;
            end
        end else begin
            hold = 0;
        end
    end

    logic [PW-1:0] all1;
    logic [PW-1:0] rp;

    initial begin
        n_chk = 0;
        n_pass = 0;
        draining = 0;
        all1 = '1;
        rst_n = 1'b0;
        clr = 1'b0;
        in_valid = 1'b0;
        in_prod = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        #23;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_sum", 256'(out_sum), 256'(0));
        chk("rst_out_count", 256'(out_count), 256'(0));
        chk("rst_out_forced", 256'(out_forced), 256'(0));
        chk("rst_out_ovf", 256'(out_ovf), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Group sum 3+5+7
        step(1, 3, 0, 1, 0);
        step(1, 5, 0, 1, 0);
        step(1, 7, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Back-pressure for 4 cycles with a beat offered
        step(1, 10, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 11, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Forced close after MAX_TERMS beats; fifth beat held off
        for (int i = 0; i < 5; i++) step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 1, 1, 0);
        step(0, 0, 0, 1, 0);

        // Overflow with three all-ones products
        step(1, all1, 0, 1, 0);
        step(1, all1, 0, 1, 0);
        step(1, all1, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // clr mid-group, then a single-beat group
        step(1, 2, 0, 1, 0);
        step(1, 2, 0, 1, 0);
        step(1, 2, 0, 1, 1);
        step(1, 9, 1, 1, 0);
        step(0, 0, 0, 1, 0);

        // clr while a result waits, with out_ready high
        step(1, 4, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(2, 0) == 0) rp = {$urandom, $urandom, $urandom, $urandom};
            else rp = PW'($urandom_range(1000, 0));
            step($urandom_range(3, 0) != 0, rp, $urandom_range(2, 0) == 0,
                 $urandom_range(3, 0) != 0, $urandom_range(24, 0) == 0);
        end

        // Drain outstanding results within a bounded number of cycles
        for (int i = 0; i < 20 && (exp_q.size() != 0 || draining); i++)
            step(0, 0, 0, 1, 0);
        chk("queue_drained", 256'(exp_q.size()), 256'(0));

        // Asynchronous reset while a result is held
        step(1, 9, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 256'(out_valid), 256'(0));
        chk("arst_out_sum", 256'(out_sum), 256'(0));
        chk("arst_out_count", 256'(out_count), 256'(0));
        chk("arst_out_forced", 256'(out_forced), 256'(0));
        chk("arst_out_ovf", 256'(out_ovf), 256'(0));
        exp_q.delete();
        terms.delete();
        draining = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prod_accum_seq.md
Name: prod_accum_seq

Overview:
- Sequential accumulation stage directly downstream of the 64x64 array multiplier.
- Consumes a stream of 128-bit unsigned products under valid/ready and sums each group of terms into a wide accumulator.
- Presents one result per group under valid/ready. A group ends on an in_last beat or when MAX_TERMS beats have been accepted.
- Dot-product/MAC engines use it behind the combinational multiplier.

Parameters:
- PROD_W, 128, product input width; must match the multiplier output.
- CNT_W, 8, term counter width.
- ACC_W, 136, accumulator/result width; must be >= PROD_W.
- MAX_TERMS, 255, forced group end after this many beats; range 1..2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush; discards partial group and any pending result
- in_valid  in  1  product beat valid
- in_ready  out  1  stage accepts beat
- in_prod  in  PROD_W  unsigned product from multiplier
- in_last  in  1  beat is final term of group
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  ACC_W  group sum
- out_count  out  CNT_W  number of terms in group
- out_forced  out  1  group closed by MAX_TERMS, not in_last
- out_ovf  out  1  accumulator wrapped (or saturated) during group

Behaviour:
- Reset: clk and reset are fixed as one clock with asynchronous active-low rst_n. Reset forces state IDLE, acc=0, count=0, out_valid=0, out_sum=0, out_count=0, out_forced=0, out_ovf=0.
- Accept rule: a beat is accepted when in_valid && in_ready.
- in_ready: in_ready = (state != DRAIN) && !clr. It is combinational from state and clr only, and never depends on in_valid.
- IDLE (no terms held), on accept:
  - acc = zero-extended in_prod; count = 1; ovf = 0.
  - Go to ACCUM, or to DRAIN if the group closes.
- ACCUM, on accept:
  - acc = acc + in_prod, mod 2^ACC_W; count++.
  - ovf |= carry out of ACC_W.
- Group close: a beat closes the group if in_last=1, or if count after increment == MAX_TERMS (then forced=1, unless in_last=1 on that same beat).
  - Closing beat accepted in cycle N: out_valid=1 in cycle N+1, carrying the updated acc, count, forced and ovf. State goes to DRAIN.
- DRAIN:
  - Outputs stay stable while out_valid && !out_ready.
  - On out_ready: out_valid drops next cycle, state goes to IDLE, acc and count clear.
  - One bubble cycle per group; no input is accepted in DRAIN.
- Throughput and latency: one beat per cycle within a group; result latency is 1 cycle after the closing beat.
- clr (any state): next state IDLE, acc=0, count=0, out_valid=0.
  - clr takes priority over an accepted beat, which is impossible anyway since in_ready=0.
  - clr also takes priority over out_ready.
- MAX_TERMS=1: every beat is its own group; forced=1 unless in_last=1.
- Input stability: in_prod, in_last and in_valid are unconstrained while !in_ready; the block must not sample them then.
- Reset mid-group: any partial sum and pending result are lost; no output is produced.

Optional Feature:
- ACC_SAT_EN defined:
  - When an addition carries out, acc becomes all-ones (2^ACC_W-1) and stays there for the rest of the group; ovf=1.
  - Count continues to increment.
- ACC_SAT_EN undefined: modular wrap as above; ovf still records any carry.

Decomposition:
- Shared package (prod_accum_pkg):
  - state enum {IDLE, ACCUM, DRAIN}
  - default width constants PROD_W=128, CNT_W=8, ACC_W=136
  - localparam ACC_MAX (all-ones)
- One natural sub-module: acc_add_sat. It is a combinational ACC_W adder taking a zero-extended PROD_W operand, with carry out. It performs the saturating select under ACC_SAT_EN.

Test Plan:
- Group sum: beats 3, 5, 7 with in_last on 7, out_ready=1 → out_valid one cycle after the last beat; out_sum=15, out_count=3, forced=0, ovf=0.
- Back-pressure: out_ready=0 for 4 cycles after a result → out_* stable and in_ready=0 throughout. out_ready=1 → next cycle out_valid=0, in_ready=1, state IDLE.
- Forced close: MAX_TERMS=4, five beats of 1 with no in_last → first result sum=4, count=4, forced=1. The fifth beat is held off by in_ready=0, then starts a new group.
- Overflow: ACC_W=129, beats 2^128-1 ×3.
  - Without ACC_SAT_EN: sum = (3·(2^128-1)) mod 2^129, ovf=1.
  - With ACC_SAT_EN: sum = 2^129-1, ovf=1.
- clr mid-group: 2 beats accepted, then clr=1 with in_valid=1 → in_ready=0 that cycle. Next group of single beat 9 with last → sum=9, count=1.
- Async reset: assert rst_n=0 with out_valid=1 and no clock edge → out_valid=0 immediately; all outputs 0.
